mem_comp_buffer: RTL
====================

// Module: mem_comp_buffer
// PURPOSE
//   Parametrised MEM->Complete stage buffer that supersedes the single-entry MEM/Complete register.
//   - Accepts results from NSRC producers (source 0 = LSQ store-to-load forward, source 1 = data memory,
//     further sources reserved), arbitrates one per cycle and queues it in a DEPTH-entry FIFO.
//   - Presents entries in order to the Complete stage with valid/ready backpressure.
//   - Each entry carries load data, PC, FU flags and the index of the source that produced it.
// PARAMETERS
//   NSRC    2    number of producer channels, >=1
//   DEPTH   4    FIFO entries, power of two, >=2
//   DW      32   load-data width
//   AW      32   PC width
//   FW      3    flag width (write, read, read_mem)
//   RR_EN   0    0: fixed priority, lowest index wins; 1: round-robin
//   SW      $clog2(NSRC) (min 1), derived; CW = $clog2(DEPTH+1), derived
// PORTS
//   clk        in   1        clock, rising edge
//   rstn       in   1        asynchronous active-low reset
//   flush      in   1        synchronous pipeline flush (mispredict/exception)
//   src_valid  in   NSRC     per-source request
//   src_ready  out  NSRC     per-source grant; one-hot or zero, combinational
//   src_data   in   NSRC*DW  packed load data, source i at [i*DW +: DW]
//   src_pc     in   NSRC*AW  packed PCs
//   src_flags  in   NSRC*FW  packed FU flags
//   out_valid  out  1        head entry valid
//   out_ready  in   1        Complete stage accepts head
//   out_data   out  DW       head load data
//   out_pc     out  AW       head PC
//   out_flags  out  FW       head flags
//   out_src    out  SW       source index of head entry
//   count      out  CW       occupied entries
//   full       out  1        count == DEPTH
// BEHAVIOUR
//   - Reset (rstn=0, async): all entries invalid; rd/wr pointers, count and rr pointer = 0.
//     out_valid=0, full=0, src_ready=0.
//   - Empty FIFO: out_data, out_pc, out_flags and out_src are forced to 0 whenever out_valid=0.
//   - Push when can_push = !flush && (!full || (out_valid && out_ready)).
//     - Grant: exactly one src_ready bit is high, namely the arbitration winner among src_valid.
//     - Losers keep ready=0, hold their request and retry next cycle.
//   - Arbitration:
//     - RR_EN=0: lowest set index wins, so the LSQ forward beats memory.
//     - RR_EN=1: search starts at rr_ptr; after a grant to index k, rr_ptr <= (k+1) mod NSRC.
//       rr_ptr holds when there is no grant.
//   - Latency: an entry accepted at edge N is visible on out_* after edge N (1-cycle latency).
//     Zero-cycle bypass is not allowed.
//   - Pop on out_valid && out_ready; the head advances at the edge.
//     out_* hold stable while out_valid && !out_ready.
//   - Simultaneous push and pop: count unchanged. This is legal at full (push slot freed by the pop)
//     and at count=1.
//   - Pointers are log2(DEPTH) bits and wrap naturally. Count saturates at neither end:
//     overflow/underflow cannot occur by construction.
//   - Order: strict FIFO. Entries from different sources are never reordered.
//   - flush=1:
//     - src_ready=0 that cycle.
//     - After the edge: count=0, pointers=0, rr_ptr=0, out_valid=0.
//     - A pop in the same cycle is ignored; flush dominates.
//   - Reset mid-operation discards all entries immediately, without waiting for the clock.
// STRUCTURE
//   - Package mem_comp_pkg:
//     - SRC_LSQ=0, SRC_MEM=1.
//     - Flag bit positions FLG_WRITE=0, FLG_READ=1, FLG_READ_MEM=2.
//     - Entry struct {data, pc, flags, src}.
//   - Sub-module mem_comp_arb (NSRC, RR_EN): inputs req, en; outputs gnt one-hot and gnt_idx;
//     owns rr_ptr.
//   - Top level: FIFO storage array, pointers, count, output muxing and zero-masking.
// TESTING
//   - Reset/idle: rstn low mid-traffic with count=3 -> out_valid=0, count=0 and src_ready=0
//     asynchronously; out_data=0.
//   - Single LSQ push: src_valid=01, data=32'hDEAD_BEEF, pc=32'h100, out_ready=1 -> src_ready=01;
//     next cycle out_valid=1, out_data=DEADBEEF, out_pc=100, out_src=0; following cycle out_valid=0.
//   - Contention, RR_EN=0: both sources valid 3 cycles, out_ready=1 -> source 0 granted every cycle,
//     source 1 starved.
//   - Contention, RR_EN=1: same stimulus -> grants alternate 0,1,0; outputs appear in that order.
//   - Fill/backpressure, DEPTH=4: out_ready=0, 5 pushes -> 4 accepted, full=1, src_ready=0 on the 5th.
//     Then out_ready=1 with source valid -> push and pop in the same cycle, count stays 4.
//     FIFO order is preserved across pointer wrap.
//   - Flush: count=3, flush=1 with src_valid=11 and out_ready=1 -> src_ready=00;
//     next cycle count=0, out_valid=0, rr_ptr=0.

Source files
------------

// File: rtl/mem_comp_pkg.sv
// Shared constants and types for the MEM->Complete stage buffer.
// Source indices, FU flag bit positions and the default-width entry layout.
package mem_comp_pkg;

    localparam int SRC_LSQ = 0;
    localparam int SRC_MEM = 1;

    localparam int FLG_WRITE    = 0;
    localparam int FLG_READ     = 1;
    localparam int FLG_READ_MEM = 2;

    localparam int DEF_DW = 32;
    localparam int DEF_AW = 32;
    localparam int DEF_FW = 3;
    localparam int DEF_SW = 1;

    typedef struct packed {
        logic [DEF_DW-1:0] data;
        logic [DEF_AW-1:0] pc;
        logic [DEF_FW-1:0] flags;
        logic [DEF_SW-1:0] src;
    } entry_t;

    // A single producer still needs a one-bit source field.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_comp_arb.sv
// Producer arbiter for the MEM->Complete buffer: fixed priority (lowest index)
// or round-robin, giving a one-hot grant plus the winning index.
module mem_comp_arb
    import mem_comp_pkg::*;
#(
    parameter int NSRC  = 2,
    parameter bit RR_EN = 1'b0,
    parameter int SW    = sel_width(NSRC)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            en,
    input  logic [NSRC-1:0] req,
    output logic [NSRC-1:0] gnt,
    output logic [SW-1:0]   gnt_idx
);

    localparam int CW1 = SW + 1;

    logic [SW-1:0]  r_rr_ptr;
    logic [CW1-1:0] w_start;
    logic [CW1-1:0] w_cand;
    logic           w_any;

    // Walk the requests circularly from the start point; the first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_any   = 1'b0;
        w_start = RR_EN ? {1'b0, r_rr_ptr} : '0;
        w_cand  = '0;
        for (int k = 0; k < NSRC; k++) begin
            w_cand = w_start + CW1'(k);
            if (w_cand >= CW1'(NSRC)) begin
                w_cand = w_cand - CW1'(NSRC);
            end
            if (en && !w_any && req[w_cand[SW-1:0]]) begin
                gnt[w_cand[SW-1:0]] = 1'b1;
                gnt_idx             = w_cand[SW-1:0];
                w_any               = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr <= '0;
        end else if (flush) begin
            r_rr_ptr <= '0;
        end else if (RR_EN && w_any) begin
            r_rr_ptr <= (gnt_idx == SW'(NSRC - 1)) ? '0 : gnt_idx + SW'(1);
        end
    end

endmodule

// File: rtl/mem_comp_buffer.sv
// MEM->Complete stage buffer: arbitrates NSRC producers into a DEPTH-entry FIFO
// and presents the head to the Complete stage with valid/ready handshaking.
module mem_comp_buffer
    import mem_comp_pkg::*;
#(
    parameter int NSRC  = 2,
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int FW    = 3,
    parameter bit RR_EN = 1'b0,
    localparam int SW   = sel_width(NSRC),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush,
    input  logic [NSRC-1:0]    src_valid,
    output logic [NSRC-1:0]    src_ready,
    input  logic [NSRC*DW-1:0] src_data,
    input  logic [NSRC*AW-1:0] src_pc,
    input  logic [NSRC*FW-1:0] src_flags,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [AW-1:0]      out_pc,
    output logic [FW-1:0]      out_flags,
    output logic [SW-1:0]      out_src,
    output logic [CW-1:0]      count,
    output logic               full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = DW + AW + FW + SW;

    logic [EW-1:0]   r_mem [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic [NSRC-1:0] w_gnt;
    logic [SW-1:0]   w_gnt_idx;
    logic            w_full;
    logic            w_valid;
    logic            w_can_push;
    logic            w_push;
    logic            w_pop;
    logic [DW-1:0]   w_sel_data;
    logic [AW-1:0]   w_sel_pc;
    logic [FW-1:0]   w_sel_flags;
    logic [EW-1:0]   w_head;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && out_ready && !flush;
    // A pop this cycle frees a slot even when full; rstn gating keeps grants off during reset.
    assign w_can_push = rstn && !flush && (!w_full || (w_valid && out_ready));
    assign w_push     = |w_gnt;

    mem_comp_arb #(
        .NSRC  (NSRC),
        .RR_EN (RR_EN),
        .SW    (SW)
    ) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (flush),
        .en      (w_can_push),
        .req     (src_valid),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    always_comb begin
        w_sel_data  = '0;
        w_sel_pc    = '0;
        w_sel_flags = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (w_gnt[i]) begin
                w_sel_data  = src_data[i*DW +: DW];
                w_sel_pc    = src_pc[i*AW +: AW];
                w_sel_flags = src_flags[i*FW +: FW];
            end
        end
    end

    // Storage needs no reset: occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_sel_data, w_sel_pc, w_sel_flags, w_gnt_idx};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = w_valid;
    assign out_data  = w_valid ? w_head[EW-1 -: DW]   : '0;
    assign out_pc    = w_valid ? w_head[SW+FW +: AW]  : '0;
    assign out_flags = w_valid ? w_head[SW +: FW]     : '0;
    assign out_src   = w_valid ? w_head[SW-1:0]       : '0;
    assign count     = r_count;
    assign full      = w_full;
    assign src_ready = w_gnt;

endmodule
